mp_mgmt_csr: RTL and testbench
==============================

Name: mp_mgmt_csr

Overview:
- Management-bus target that terminates the mgmt_* request port of the EVB execution unit.
- Holds the machine control registers consumed by the branch unit: mvec, mepc, mie, plus a 32-bit compare timer and interrupt encoder that drive exi/exi_code.
- Captures the exception PC on interrupt entry and restores mie on mret.

Parameters:
- RD_LAT, 1, cycles between mgmt_ack and mgmt_rxe on a read (0..15).
- TMR_CODE, 5'd1, exi_code reported for a timer interrupt.
- EXT_CODE, 5'd2, exi_code reported for ext_irq; the timer takes priority.

Ports:
- sysclk  in  1  clock.
- sys_setn  in  1  reset, synchronous, active-high.
- mgmt_req  in  1  request, held until acked.
- mgmt_adr  in  32  register index; only [12:0] decoded.
- mgmt_rwn  in  1  1 = read, 0 = write.
- mgmt_wen  in  2  half enables: [1] = bits 31:16, [0] = bits 15:0; 00 = dummy.
- mgmt_txd  in  32  write data.
- mgmt_ack  out  1  one-cycle accept pulse.
- mgmt_rxe  out  1  one-cycle read-data-valid pulse.
- mgmt_rxd  out  32  read data, held until the next read.
- irq_take  in  1  branch unit entered the interrupt vector this cycle.
- mret_take  in  1  mret executed this cycle.
- epc_in  in  32  pc_epc from the branch unit.
- ext_irq  in  1  level external interrupt.
- mvec  out  32  interrupt vector base.
- mepc  out  32  exception return PC.
- mie  out  1  interrupt enable.
- exi  out  1  interrupt request level.
- exi_code  out  5  interrupt cause.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; internal registers 0.
- Register map (mgmt_adr[12:0]):
  - 0x000 MVEC: rw; bits [8:0] read 0.
  - 0x001 MEPC: rw.
  - 0x002 STAT: bit0 = mie (rw); bit1 = tpend (write-1-clear).
  - 0x003 TCNT: rw.
  - 0x004 TCMP: rw.
  - 0x005 TCTL: bit0 = en, bit1 = autoreload.
  - Any other index reads 0, ignores writes, and is still acknowledged.
- FSM states: IDLE, ACK, WAIT, RDY.
  - IDLE with mgmt_req=1 → ACK. The next cycle has mgmt_ack=1.
  - Write: the masked write commits on the ACK cycle, then IDLE.
  - Read: the addressed register is snapshotted on the ACK cycle.
    - RD_LAT=0: rxe coincides with ack.
    - RD_LAT>0: WAIT counts RD_LAT-1 cycles, then RDY pulses rxe with rxd = snapshot, then IDLE.
  - Requests are not sampled outside IDLE. The requester drops req on the edge after ack, so the stale req seen in the ACK cycle is ignored.
  - Latency from req to ack is 1 cycle.
  - Read latency from req to rxe is RD_LAT+1 cycles.
- Half writes: each 16-bit half is updated only if its wen bit is set. wen=00 is acknowledged with no state change.
- Timer:
  - When en=1, TCNT increments by 1 each cycle and wraps modulo 2^32.
  - When TCNT==TCMP and en=1: tpend is set. With autoreload=1, TCNT loads 0 next cycle; otherwise it continues counting.
  - A bus write to TCNT in the same cycle as an increment: the write wins.
  - tpend set and a w1c in the same cycle: the set wins.
- Interrupt output:
  - exi = mie & (tpend | ext_irq), registered, 1-cycle latency.
  - exi_code = TMR_CODE if tpend, else EXT_CODE.
- irq_take: mepc ← epc_in and mie ← 0 next edge. This takes priority over a bus write to MEPC or STAT in the same cycle.
- mret_take: mie ← 1. If irq_take is also asserted in the same cycle, irq_take wins.
- Reset asserted mid-transaction: the FSM returns to IDLE and no ack or rxe is produced afterwards.

Test Plan:
- Reset, then read 0x000 with RD_LAT=1 → ack 1 cycle after req, rxe 2 cycles after req, rxd=0x00000000.
- Write 0x001 data 0x12345678 with wen=10, then read it → rxd=0x12340000; then wen=01 data 0xAAAA5555 → rxd=0x12345555.
- Timer:
  - Setup: TCMP=5, TCTL=3 (en + autoreload), STAT=1.
  - Expected: TCNT sequence 0..5,0..; tpend set and exi=1 with exi_code=1 one cycle after TCNT==5.
  - Write STAT=0x3 → tpend cleared, mie stays 1.
- irq_take with epc_in=0x00000104 while a MEPC write of 0xDEAD0000 commits in the same cycle → mepc=0x00000104, mie=0. mret_take → mie=1.
- Read 0x1FFF (unmapped) → ack and rxe pulse, rxd=0. Dummy write (wen=00) to 0x000 → ack, mvec unchanged.
- Assert sys_setn during WAIT (RD_LAT=4) → no rxe pulse; the next request completes normally with all registers at 0.

Source files
------------

// File: rtl/mp_mgmt_csr.sv
// Management-bus CSR target: machine vector/EPC/interrupt-enable registers,
// a compare timer, and the interrupt request encoder for the branch unit.
module mp_mgmt_csr #(
    parameter int         RD_LAT   = 1,
    parameter logic [4:0] TMR_CODE = 5'd1,
    parameter logic [4:0] EXT_CODE = 5'd2
) (
    input  logic        sysclk,
    input  logic        sys_setn,
    input  logic        mgmt_req,
    input  logic [31:0] mgmt_adr,
    input  logic        mgmt_rwn,
    input  logic [1:0]  mgmt_wen,
    input  logic [31:0] mgmt_txd,
    output logic        mgmt_ack,
    output logic        mgmt_rxe,
    output logic [31:0] mgmt_rxd,
    input  logic        irq_take,
    input  logic        mret_take,
    input  logic [31:0] epc_in,
    input  logic        ext_irq,
    output logic [31:0] mvec,
    output logic [31:0] mepc,
    output logic        mie,
    output logic        exi,
    output logic [4:0]  exi_code,
    output logic [1:0]  dbg_state
);
    // Handshake: mgmt_req is held until mgmt_ack pulses; mgmt_rxe pulses once
    // per read with mgmt_rxd valid from that cycle until the next read.
    typedef enum logic [1:0] {IDLE, ACK, WAIT, RDY} state_t;
    state_t state;

    logic [12:0] lat_adr;
    logic        lat_rwn;
    logic [1:0]  lat_wen;
    logic [31:0] lat_txd;
    logic [31:0] snap;
    logic [3:0]  wcnt;

    logic [31:0] tcnt, tcmp;
    logic        tpend, t_en, t_ar;

    logic [31:0] mvec_n, mepc_n, tcnt_n, tcmp_n;
    logic        mie_n, tpend_n, en_n, ar_n;
    logic [12:0] sel_adr;
    logic [31:0] rdata;
    logic        wr, hit;
    logic        unused_adr_hi;

    assign unused_adr_hi = ^mgmt_adr[31:13];
    assign dbg_state     = state;
    assign wr            = (state == ACK) && !lat_rwn;
    assign hit           = t_en && (tcnt == tcmp);

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [1:0]  en);
        merge = {en[1] ? new_v[31:16] : old_v[31:16],
                 en[0] ? new_v[15:0]  : old_v[15:0]};
    endfunction

    // Live address in IDLE serves the zero-latency read; otherwise the latched one.
    always_comb begin
        sel_adr = (state == IDLE) ? mgmt_adr[12:0] : lat_adr;
        rdata   = 32'h0;
        case (sel_adr)
            13'h000: rdata = mvec;
            13'h001: rdata = mepc;
            13'h002: rdata = {30'h0, tpend, mie};
            13'h003: rdata = tcnt;
            13'h004: rdata = tcmp;
            13'h005: rdata = {30'h0, t_ar, t_en};
            default: rdata = 32'h0;
        endcase
    end

    always_comb begin
        mvec_n  = mvec;
        mepc_n  = mepc;
        mie_n   = mie;
        tpend_n = tpend;
        tcmp_n  = tcmp;
        en_n    = t_en;
        ar_n    = t_ar;
        tcnt_n  = t_en ? ((hit && t_ar) ? 32'h0 : tcnt + 32'h1) : tcnt;
        if (wr) begin
            case (lat_adr)
                13'h000: mvec_n = merge(mvec, lat_txd, lat_wen) & 32'hFFFF_FE00;
                13'h001: mepc_n = merge(mepc, lat_txd, lat_wen);
                13'h002: if (lat_wen[0]) begin
                    mie_n = lat_txd[0];
                    if (lat_txd[1]) tpend_n = 1'b0;
                end
                13'h003: tcnt_n = merge(tcnt, lat_txd, lat_wen);
                13'h004: tcmp_n = merge(tcmp, lat_txd, lat_wen);
                13'h005: if (lat_wen[0]) {ar_n, en_n} = lat_txd[1:0];
                default: ;
            endcase
        end
        // Later assignments win: timer set over w1c, irq_take over mret and bus.
        if (hit)       tpend_n = 1'b1;
        if (mret_take) mie_n   = 1'b1;
        if (irq_take) begin
            mepc_n = epc_in;
            mie_n  = 1'b0;
        end
    end

    always_ff @(posedge sysclk) begin
        if (sys_setn) begin
            mvec     <= 32'h0;
            mepc     <= 32'h0;
            mie      <= 1'b0;
            tpend    <= 1'b0;
            tcnt     <= 32'h0;
            tcmp     <= 32'h0;
            t_en     <= 1'b0;
            t_ar     <= 1'b0;
            exi      <= 1'b0;
            exi_code <= 5'd0;
        end else begin
            mvec     <= mvec_n;
            mepc     <= mepc_n;
            mie      <= mie_n;
            tpend    <= tpend_n;
            tcnt     <= tcnt_n;
            tcmp     <= tcmp_n;
            t_en     <= en_n;
            t_ar     <= ar_n;
            exi      <= mie_n & (tpend_n | ext_irq);
            exi_code <= tpend_n ? TMR_CODE : EXT_CODE;
        end
    end

    always_ff @(posedge sysclk) begin
        if (sys_setn) begin
            state    <= IDLE;
            mgmt_ack <= 1'b0;
            mgmt_rxe <= 1'b0;
            mgmt_rxd <= 32'h0;
            snap     <= 32'h0;
            wcnt     <= 4'h0;
            lat_adr  <= 13'h0;
            lat_rwn  <= 1'b0;
            lat_wen  <= 2'b00;
            lat_txd  <= 32'h0;
        end else begin
            mgmt_ack <= 1'b0;
            mgmt_rxe <= 1'b0;
            case (state)
                IDLE: if (mgmt_req) begin
                    state    <= ACK;
                    mgmt_ack <= 1'b1;
                    lat_adr  <= mgmt_adr[12:0];
                    lat_rwn  <= mgmt_rwn;
                    lat_wen  <= mgmt_wen;
                    lat_txd  <= mgmt_txd;
                    if (RD_LAT == 0 && mgmt_rwn) begin
                        mgmt_rxe <= 1'b1;
                        mgmt_rxd <= rdata;
                    end
                end
                ACK: begin
                    if (!lat_rwn || RD_LAT == 0) begin
                        state <= IDLE;
                    end else if (RD_LAT == 1) begin
                        state    <= RDY;
                        mgmt_rxe <= 1'b1;
                        mgmt_rxd <= rdata;
                    end else begin
                        snap  <= rdata;
                        wcnt  <= 4'(RD_LAT - 2);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (wcnt == 4'h0) begin
                        state    <= RDY;
                        mgmt_rxe <= 1'b1;
                        mgmt_rxd <= snap;
                    end else begin
                        wcnt <= wcnt - 4'h1;
                    end
                end
                RDY: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mp_mgmt_csr.sv
// Directed bench for mp_mgmt_csr: a table of bus transactions against an
// RD_LAT=1 instance, then timer, interrupt and mid-read reset sequences.
module tb_mp_mgmt_csr;
    logic        clk = 1'b0;
    logic        rst1, rst4, req1, req4;
    logic [31:0] adr, txd, epc_in;
    logic        rwn, irq_take, mret_take, ext_irq;
    logic [1:0]  wen;

    logic        ack1, rxe1, mie1, exi1;
    logic [31:0] rxd1, mvec1, mepc1;
    logic [4:0]  code1;
    logic [1:0]  st1;
    logic        ack4, rxe4, mie4, exi4;
    logic [31:0] rxd4, mvec4, mepc4;
    logic [4:0]  code4;
    logic [1:0]  st4;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] adr;
        bit          rwn;
        logic [1:0]  wen;
        logic [31:0] txd;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t tbl[14];

    mp_mgmt_csr #(.RD_LAT(1)) dut (
        .sysclk(clk), .sys_setn(rst1), .mgmt_req(req1), .mgmt_adr(adr),
        .mgmt_rwn(rwn), .mgmt_wen(wen), .mgmt_txd(txd), .mgmt_ack(ack1),
        .mgmt_rxe(rxe1), .mgmt_rxd(rxd1), .irq_take(irq_take),
        .mret_take(mret_take), .epc_in(epc_in), .ext_irq(ext_irq),
        .mvec(mvec1), .mepc(mepc1), .mie(mie1), .exi(exi1),
        .exi_code(code1), .dbg_state(st1)
    );

    mp_mgmt_csr #(.RD_LAT(4)) dut4 (
        .sysclk(clk), .sys_setn(rst4), .mgmt_req(req4), .mgmt_adr(adr),
        .mgmt_rwn(rwn), .mgmt_wen(wen), .mgmt_txd(txd), .mgmt_ack(ack4),
        .mgmt_rxe(rxe4), .mgmt_rxd(rxd4), .irq_take(irq_take),
        .mret_take(mret_take), .epc_in(epc_in), .ext_irq(ext_irq),
        .mvec(mvec4), .mepc(mepc4), .mie(mie4), .exi(exi4),
        .exi_code(code4), .dbg_state(st4)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp_v);
        end
    endtask

    // One bus transaction; reads pop their expected data from exp_q.
    task automatic xact(input bit sel, input logic [31:0] a, input bit r,
                        input logic [1:0] w, input logic [31:0] d);
        int cyc;
        logic [31:0] e;
        @(negedge clk);
        adr = a; rwn = r; wen = w; txd = d;
        if (sel) req4 = 1'b1; else req1 = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(sel ? ack4 : ack1) && cyc < 10);
        check("ack_lat", cyc, 1);
        @(posedge clk);
        #1;
        req1 = 1'b0;
        req4 = 1'b0;
        if (r) begin
            do begin
                @(negedge clk);
                cyc++;
            end while (!(sel ? rxe4 : rxe1) && cyc < 30);
            check("rd_lat", cyc, sel ? 5 : 2);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            check("rxd", sel ? rxd4 : rxd1, e);
        end
    endtask

    initial begin
        int viol;
        tbl[0]  = '{32'h000, 1'b1, 2'b00, 32'h0,         32'h0000_0000};
        tbl[1]  = '{32'h001, 1'b0, 2'b10, 32'h1234_5678, 32'h0};
        tbl[2]  = '{32'h001, 1'b1, 2'b00, 32'h0,         32'h1234_0000};
        tbl[3]  = '{32'h001, 1'b0, 2'b01, 32'hAAAA_5555, 32'h0};
        tbl[4]  = '{32'h001, 1'b1, 2'b00, 32'h0,         32'h1234_5555};
        tbl[5]  = '{32'h000, 1'b0, 2'b11, 32'hFFFF_FFFF, 32'h0};
        tbl[6]  = '{32'h000, 1'b1, 2'b00, 32'h0,         32'hFFFF_FE00};
        tbl[7]  = '{32'h000, 1'b0, 2'b00, 32'h0000_0000, 32'h0};
        tbl[8]  = '{32'h000, 1'b1, 2'b00, 32'h0,         32'hFFFF_FE00};
        tbl[9]  = '{32'h1FFF, 1'b0, 2'b11, 32'hFFFF_FFFF, 32'h0};
        tbl[10] = '{32'h1FFF, 1'b1, 2'b00, 32'h0,        32'h0000_0000};
        tbl[11] = '{32'h2001, 1'b1, 2'b00, 32'h0,        32'h1234_5555};
        tbl[12] = '{32'h004, 1'b0, 2'b11, 32'h0000_ABCD, 32'h0};
        tbl[13] = '{32'h004, 1'b1, 2'b00, 32'h0,         32'h0000_ABCD};

        rst1 = 1'b1; rst4 = 1'b1; req1 = 1'b0; req4 = 1'b0;
        adr = '0; txd = '0; rwn = 1'b0; wen = 2'b00;
        irq_take = 1'b0; mret_take = 1'b0; epc_in = '0; ext_irq = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack_rxe", {30'h0, ack1, rxe1}, 32'h0);
        check("rst_rxd", rxd1, 32'h0);
        check("rst_mvec_mepc", mvec1 | mepc1, 32'h0);
        check("rst_mie_exi_code", {25'h0, mie1, exi1, code1}, 32'h0);
        check("rst_state", {30'h0, st1}, 32'h0);
        rst1 = 1'b0;

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].rwn) exp_q.push_back(tbl[i].exp_rd);
            xact(1'b0, tbl[i].adr, tbl[i].rwn, tbl[i].wen, tbl[i].txd);
        end
        check("mvec_port", mvec1, 32'hFFFF_FE00);
        check("mepc_port", mepc1, 32'h1234_5555);
        xact(1'b0, 32'h003, 1'b0, 2'b11, 32'h0);
        check("rxd_held", rxd1, 32'h0000_ABCD);

        // Timer: compare 5, enable with autoreload, interrupts on.
        xact(1'b0, 32'h004, 1'b0, 2'b11, 32'h5);
        xact(1'b0, 32'h002, 1'b0, 2'b11, 32'h1);
        xact(1'b0, 32'h005, 1'b0, 2'b11, 32'h3);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("tcnt_%0d", k), dut.tcnt, k % 6);
            if (k == 5) check("exi_before_hit", {31'h0, exi1}, 32'h0);
            if (k == 6) begin
                check("exi_on_hit", {31'h0, exi1}, 32'h1);
                check("exi_code_tmr", {27'h0, code1}, 32'd1);
            end
        end
        xact(1'b0, 32'h005, 1'b0, 2'b01, 32'h0);
        xact(1'b0, 32'h002, 1'b0, 2'b01, 32'h3);
        check("w1c_mie", {31'h0, mie1}, 32'h1);
        check("w1c_exi", {31'h0, exi1}, 32'h0);
        check("code_ext_idle", {27'h0, code1}, 32'd2);
        exp_q.push_back(32'h1);
        xact(1'b0, 32'h002, 1'b1, 2'b00, 32'h0);
        exp_q.push_back(32'h2);
        xact(1'b0, 32'h003, 1'b1, 2'b00, 32'h0);

        @(negedge clk);
        ext_irq = 1'b1;
        @(negedge clk);
        check("ext_exi", {31'h0, exi1}, 32'h1);
        check("ext_code", {27'h0, code1}, 32'd2);
        ext_irq = 1'b0;
        @(negedge clk);
        check("ext_exi_drop", {31'h0, exi1}, 32'h0);

        // irq_take lands on the same edge as a MEPC bus write.
        @(negedge clk);
        adr = 32'h001; rwn = 1'b0; wen = 2'b11; txd = 32'hDEAD_0000; req1 = 1'b1;
        @(negedge clk);
        check("irq_wr_ack", {31'h0, ack1}, 32'h1);
        irq_take = 1'b1; epc_in = 32'h0000_0104;
        @(posedge clk);
        #1;
        irq_take = 1'b0; req1 = 1'b0;
        @(negedge clk);
        check("irq_mepc", mepc1, 32'h0000_0104);
        check("irq_mie", {31'h0, mie1}, 32'h0);
        mret_take = 1'b1;
        @(negedge clk);
        mret_take = 1'b0;
        check("mret_mie", {31'h0, mie1}, 32'h1);
        irq_take = 1'b1; mret_take = 1'b1; epc_in = 32'h0000_0200;
        @(negedge clk);
        irq_take = 1'b0; mret_take = 1'b0;
        check("both_mie", {31'h0, mie1}, 32'h0);
        check("both_mepc", mepc1, 32'h0000_0200);

        // RD_LAT=4 instance: reset during WAIT kills the read.
        @(negedge clk);
        rst4 = 1'b0;
        xact(1'b1, 32'h001, 1'b0, 2'b11, 32'h5A5A_5A5A);
        exp_q.push_back(32'h5A5A_5A5A);
        xact(1'b1, 32'h001, 1'b1, 2'b00, 32'h0);
        @(negedge clk);
        adr = 32'h001; rwn = 1'b1; wen = 2'b00; req4 = 1'b1;
        @(negedge clk);
        check("lat4_ack", {31'h0, ack4}, 32'h1);
        @(posedge clk);
        #1;
        req4 = 1'b0;
        @(negedge clk);
        check("lat4_in_wait", {30'h0, st4}, 32'd2);
        rst4 = 1'b1;
        viol = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 2) rst4 = 1'b0;
            if (ack4 || rxe4) viol++;
        end
        check("no_pulse_after_rst", viol, 0);
        check("lat4_mepc_rst", mepc4, 32'h0);
        exp_q.push_back(32'h0);
        xact(1'b1, 32'h001, 1'b1, 2'b00, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
